// File: rtl/tnoc_vc_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tnoc_vc_output_arbiter_if
// Brief    : Flit-side and link-side signal bundle of the VC output arbiter.
//            The slave modport faces the arbiter. The master modport faces
//            the crossbar and link environment.
// Revision : 1.0 - initial release
// ============================================================================
interface tnoc_vc_output_arbiter_if #(
  parameter int INPUTS     = 5,
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64
);
  logic [INPUTS*CHANNELS-1:0]            i_flit_valid;
  logic [INPUTS*CHANNELS-1:0]            i_flit_head;
  logic [INPUTS*CHANNELS-1:0]            i_flit_tail;
  logic [INPUTS*CHANNELS*FLIT_WIDTH-1:0] i_flit_data;
  logic [INPUTS*CHANNELS-1:0]            o_flit_ready;
  logic [CHANNELS-1:0]                   o_out_valid;
  logic                                  o_out_head;
  logic                                  o_out_tail;
  logic [FLIT_WIDTH-1:0]                 o_out_data;
  logic [CHANNELS-1:0]                   i_out_ready;

  modport slave (
    input  i_flit_valid, i_flit_head, i_flit_tail, i_flit_data, i_out_ready,
    output o_flit_ready, o_out_valid, o_out_head, o_out_tail, o_out_data
  );

  modport master (
    output i_flit_valid, i_flit_head, i_flit_tail, i_flit_data, i_out_ready,
    input  o_flit_ready, o_out_valid, o_out_head, o_out_tail, o_out_data
  );
endinterface
`default_nettype wire

// File: rtl/tnoc_vc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tnoc_vc_output_arbiter
// Brief    : Router output stage that merges INPUTS x CHANNELS flit sources
//            into one registered output port. Each VC is wormhole-locked to
//            one input per packet, and VCs interleave flit by flit.
// Revision : 1.0 - initial release
// ============================================================================
module tnoc_vc_output_arbiter #(
  parameter int INPUTS      = 5,
  parameter int CHANNELS    = 2,
  parameter int FLIT_WIDTH  = 64,
  parameter int VC_PRIORITY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  tnoc_vc_output_arbiter_if.slave  bus
);
  localparam int IW = (INPUTS > 1)   ? $clog2(INPUTS)   : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Per-VC wormhole lock and input round-robin pointer
  logic [CHANNELS-1:0]   r_locked;
  logic [IW-1:0]         r_owner  [CHANNELS];
  logic [IW-1:0]         r_in_ptr [CHANNELS];
  logic [CW-1:0]         r_vc_ptr;

  // Output flit register
  logic [CHANNELS-1:0]   r_out_valid;
  logic                  r_out_head;
  logic                  r_out_tail;
  logic [FLIT_WIDTH-1:0] r_out_data;

  logic [CHANNELS-1:0]   w_has_cand;
  logic [IW-1:0]         w_cand [CHANNELS];
  logic [CHANNELS-1:0]   w_elig;
  logic [CW-1:0]         w_sel;
  logic                  w_sel_valid;
  logic [IW-1:0]         w_sel_in;
  logic                  w_sel_head;
  logic                  w_sel_tail;
  logic [FLIT_WIDTH-1:0] w_sel_data;
  logic                  w_load;
  logic                  w_accept;
  logic [INPUTS*CHANNELS-1:0] w_flit_ready;

  // Candidate per VC: locked owner if its flit is valid, else RR winner among heads
  always_comb begin
    int p;
    p = 0;
    w_has_cand = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      w_cand[v] = '0;
      if (r_locked[v]) begin
        w_cand[v] = r_owner[v];
        for (int q = 0; q < INPUTS; q++) begin
          if (int'(r_owner[v]) == q && bus.i_flit_valid[q*CHANNELS+v]) begin
            w_has_cand[v] = 1'b1;
          end
        end
      end else begin
        // Scan from the farthest offset down so the nearest request wins
        for (int k = INPUTS - 1; k >= 0; k--) begin
          p = int'(r_in_ptr[v]) + k;
          if (p >= INPUTS) p = p - INPUTS;
          if (bus.i_flit_valid[p*CHANNELS+v] && bus.i_flit_head[p*CHANNELS+v]) begin
            w_has_cand[v] = 1'b1;
            w_cand[v]     = IW'(p);
          end
        end
      end
    end
  end

  assign w_elig   = w_has_cand & bus.i_out_ready;
  assign w_load   = (r_out_valid == '0) || ((r_out_valid & bus.i_out_ready) != '0);
  assign w_accept = w_load && w_sel_valid;

  // VC select: highest eligible index, or round-robin from the VC pointer
  always_comb begin
    int c;
    c           = 0;
    w_sel       = '0;
    w_sel_valid = 1'b0;
    if (VC_PRIORITY != 0) begin
      for (int v = 0; v < CHANNELS; v++) begin
        if (w_elig[v]) begin
          w_sel       = CW'(v);
          w_sel_valid = 1'b1;
        end
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        c = int'(r_vc_ptr) + k;
        if (c >= CHANNELS) c = c - CHANNELS;
        if (w_elig[c]) begin
          w_sel       = CW'(c);
          w_sel_valid = 1'b1;
        end
      end
    end
  end

  // Mux out the selected flit and raise its single ready bit
  always_comb begin
    int idx;
    w_sel_in = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      if (CW'(v) == w_sel) w_sel_in = w_cand[v];
    end
    idx          = int'(w_sel_in) * CHANNELS + int'(w_sel);
    w_sel_head   = bus.i_flit_head[idx];
    w_sel_tail   = bus.i_flit_tail[idx];
    w_sel_data   = bus.i_flit_data[idx*FLIT_WIDTH +: FLIT_WIDTH];
    w_flit_ready = '0;
    if (w_accept && !rst) w_flit_ready[idx] = 1'b1;
  end

  // Output register: refills whenever it is empty or draining this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= '0;
      r_out_head  <= 1'b0;
      r_out_tail  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= '0;
      if (w_accept) begin
        r_out_valid[w_sel] <= 1'b1;
        r_out_head         <= w_sel_head;
        r_out_tail         <= w_sel_tail;
        r_out_data         <= w_sel_data;
      end
    end
  end

  // Lock, input-pointer and VC-pointer updates on each accepted flit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked <= '0;
      r_vc_ptr <= '0;
      for (int v = 0; v < CHANNELS; v++) begin
        r_owner[v]  <= '0;
        r_in_ptr[v] <= '0;
      end
    end else if (w_accept) begin
      if (!r_locked[w_sel] && w_sel_head) begin
        r_in_ptr[w_sel] <= (int'(w_sel_in) == INPUTS - 1) ? '0 : w_sel_in + 1'b1;
      end
      if (w_sel_tail) begin
        r_locked[w_sel] <= 1'b0;
      end else if (w_sel_head) begin
        r_locked[w_sel] <= 1'b1;
        r_owner[w_sel]  <= w_sel_in;
      end
      if (VC_PRIORITY == 0) begin
        r_vc_ptr <= (int'(w_sel) == CHANNELS - 1) ? '0 : w_sel + 1'b1;
      end
    end
  end

  assign bus.o_flit_ready = w_flit_ready;
  assign bus.o_out_valid  = r_out_valid;
  assign bus.o_out_head   = r_out_head;
  assign bus.o_out_tail   = r_out_tail;
  assign bus.o_out_data   = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_tnoc_vc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tnoc_vc_output_arbiter
// Brief    : Self-checking bench for the VC output arbiter. A round-robin
//            instance and a fixed-priority instance share one stimulus and
//            are compared cycle by cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tnoc_vc_output_arbiter;
  localparam int N  = 5;
  localparam int C  = 2;
  localparam int W  = 32;
  localparam int NC = N * C;

  typedef struct packed {
    logic         h;
    logic         t;
    logic [W-1:0] d;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0]   flit_valid;
  logic [NC-1:0]   flit_head;
  logic [NC-1:0]   flit_tail;
  logic [NC*W-1:0] flit_data;
  logic [C-1:0]    out_ready;

  tnoc_vc_output_arbiter_if #(.INPUTS(N), .CHANNELS(C), .FLIT_WIDTH(W)) bus0 ();
  tnoc_vc_output_arbiter_if #(.INPUTS(N), .CHANNELS(C), .FLIT_WIDTH(W)) bus1 ();

  assign bus0.i_flit_valid = flit_valid;
  assign bus0.i_flit_head  = flit_head;
  assign bus0.i_flit_tail  = flit_tail;
  assign bus0.i_flit_data  = flit_data;
  assign bus0.i_out_ready  = out_ready;
  assign bus1.i_flit_valid = flit_valid;
  assign bus1.i_flit_head  = flit_head;
  assign bus1.i_flit_tail  = flit_tail;
  assign bus1.i_flit_data  = flit_data;
  assign bus1.i_out_ready  = out_ready;

  tnoc_vc_output_arbiter #(.INPUTS(N), .CHANNELS(C), .FLIT_WIDTH(W), .VC_PRIORITY(0))
    u_dut_rr (.clk(clk), .rst(rst), .bus(bus0));
  tnoc_vc_output_arbiter #(.INPUTS(N), .CHANNELS(C), .FLIT_WIDTH(W), .VC_PRIORITY(1))
    u_dut_fp (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  // Reference state: index 0 models round-robin VC select, 1 models fixed priority
  int           m_locked [2][C];
  int           m_owner  [2][C];
  int           m_iptr   [2][C];
  int           m_vptr   [2];
  logic [C-1:0] m_ov     [2];
  logic         m_oh     [2];
  logic         m_ot     [2];
  logic [W-1:0] m_od     [2];

  flit_t        srcq [NC][$];
  logic [W-1:0] obs [$];
  logic [NC-1:0] acc0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_vptr[m] = 0; m_ov[m] = '0; m_oh[m] = 1'b0; m_ot[m] = 1'b0; m_od[m] = '0;
      for (int v = 0; v < C; v++) begin
        m_locked[m][v] = 0; m_owner[m][v] = 0; m_iptr[m][v] = 0;
      end
    end
  endtask

  // Apply the arbitration rules to the current inputs, check ready, advance state
  task automatic model_step(input int m);
    bit            has  [C];
    int            cand [C];
    bit            elig [C];
    bit            load;
    int            sel, p, v, idx;
    logic [NC-1:0] exp_rdy;
    for (int vc = 0; vc < C; vc++) begin
      has[vc] = 0; cand[vc] = 0;
      if (m_locked[m][vc] != 0) begin
        if (flit_valid[m_owner[m][vc]*C+vc]) begin has[vc] = 1; cand[vc] = m_owner[m][vc]; end
      end else begin
        for (int k = 0; k < N; k++) begin
          p = (m_iptr[m][vc] + k) % N;
          if (!has[vc] && flit_valid[p*C+vc] && flit_head[p*C+vc]) begin has[vc] = 1; cand[vc] = p; end
        end
      end
      elig[vc] = has[vc] && out_ready[vc];
    end
    load = (m_ov[m] == '0) || ((m_ov[m] & out_ready) != '0);
    sel = -1;
    if (m == 1) begin
      for (int vc = 0; vc < C; vc++) if (elig[vc]) sel = vc;
    end else begin
      for (int k = 0; k < C; k++) begin
        v = (m_vptr[m] + k) % C;
        if (sel < 0 && elig[v]) sel = v;
      end
    end
    if (!load) sel = -1;
    exp_rdy = '0;
    idx = 0;
    if (sel >= 0) begin idx = cand[sel] * C + sel; exp_rdy[idx] = 1'b1; end
    check_eq($sformatf("flit_ready%0d", m),
             64'((m == 0) ? bus0.o_flit_ready : bus1.o_flit_ready), 64'(exp_rdy));
    if (load) m_ov[m] = '0;
    if (sel >= 0) begin
      m_ov[m][sel] = 1'b1;
      m_oh[m] = flit_head[idx];
      m_ot[m] = flit_tail[idx];
      m_od[m] = flit_data[idx*W +: W];
      if (m_locked[m][sel] == 0 && flit_head[idx]) m_iptr[m][sel] = (cand[sel] + 1) % N;
      if (flit_tail[idx]) m_locked[m][sel] = 0;
      else if (flit_head[idx]) begin m_locked[m][sel] = 1; m_owner[m][sel] = cand[sel]; end
      if (m == 0) m_vptr[m] = (sel + 1) % C;
    end
  endtask

  task automatic check_inst(input int m, input logic [C-1:0] v, input logic h, input logic t,
                            input logic [W-1:0] d);
    check_eq($sformatf("out_valid%0d", m), 64'(v), 64'(m_ov[m]));
    if (m_ov[m] != '0) begin
      check_eq($sformatf("out_head%0d", m), 64'(h), 64'(m_oh[m]));
      check_eq($sformatf("out_tail%0d", m), 64'(t), 64'(m_ot[m]));
      check_eq($sformatf("out_data%0d", m), 64'(d), 64'(m_od[m]));
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_valid"}, 64'({bus0.o_out_valid, bus1.o_out_valid}), 64'd0);
    check_eq({tag, "_headtail"}, 64'({bus0.o_out_head, bus0.o_out_tail, bus1.o_out_head, bus1.o_out_tail}), 64'd0);
    check_eq({tag, "_data"}, 64'({bus0.o_out_data, bus1.o_out_data}), 64'd0);
    check_eq({tag, "_ready"}, 64'({bus0.o_flit_ready, bus1.o_flit_ready}), 64'd0);
  endtask

  // One clock: check ready against the model, record transfers, check registers after the edge
  task automatic cycle();
    #1;
    acc0 = bus0.o_flit_ready;
    if ((bus0.o_out_valid & out_ready) != '0) obs.push_back(bus0.o_out_data);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_inst(0, bus0.o_out_valid, bus0.o_out_head, bus0.o_out_tail, bus0.o_out_data);
    check_inst(1, bus1.o_out_valid, bus1.o_out_head, bus1.o_out_tail, bus1.o_out_data);
  endtask

  task automatic clear_inputs();
    flit_valid = '0; flit_head = '0; flit_tail = '0; flit_data = '0;
  endtask

  task automatic set_flit(input int p, input int v, input logic h, input logic t, input logic [W-1:0] d);
    flit_valid[p*C+v] = 1'b1;
    flit_head[p*C+v]  = h;
    flit_tail[p*C+v]  = t;
    flit_data[(p*C+v)*W +: W] = d;
  endtask

  task automatic push_packet(input int p, input int v, input int len, input logic [W-1:0] base);
    for (int k = 0; k < len; k++)
      srcq[p*C+v].push_back('{h: (k == 0), t: (k == len - 1), d: base + W'(k)});
  endtask

  function automatic int queued();
    int s = 0;
    for (int i = 0; i < NC; i++) s += srcq[i].size();
    return s;
  endfunction

  task automatic drive_sources();
    clear_inputs();
    for (int i = 0; i < NC; i++) begin
      if (srcq[i].size() > 0) begin
        flit_valid[i] = 1'b1;
        flit_head[i]  = srcq[i][0].h;
        flit_tail[i]  = srcq[i][0].t;
        flit_data[i*W +: W] = srcq[i][0].d;
      end
    end
  endtask

  task automatic pop_accepted();
    for (int i = 0; i < NC; i++) if (acc0[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  endtask

  task automatic src_cycle();
    drive_sources();
    cycle();
    pop_accepted();
  endtask

  task automatic run_sources(input int budget);
    int n = 0;
    while (queued() != 0 && n < budget) begin
      src_cycle();
      n++;
    end
    check_eq("drain_left", 64'(queued()), 64'd0);
    for (int i = 0; i < NC; i++) srcq[i].delete();
    clear_inputs();
    out_ready = '1;
    repeat (2) cycle();
  endtask

  initial begin
    logic [W-1:0] exp_seq [$];
    logic [W-1:0] held;
    clear_inputs();
    out_ready = '1;
    model_reset();

    // Reset with a head already presented: ready must stay low
    set_flit(0, 0, 1'b1, 1'b1, 32'h11);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    clear_inputs();
    rst = 1'b0;
    cycle();

    // Single-flit packet on input 2, VC0
    set_flit(2, 0, 1'b1, 1'b1, 32'hA5);
    cycle();
    check_eq("single_valid", 64'(bus0.o_out_valid), 64'h1);
    check_eq("single_headtail", 64'({bus0.o_out_head, bus0.o_out_tail}), 64'h3);
    check_eq("single_data", 64'(bus0.o_out_data), 64'hA5);
    clear_inputs();
    cycle();

    // Two inputs contend on VC0; the second packet of input 0 must wait for input 1
    obs.delete();
    push_packet(0, 0, 4, 32'h100);
    push_packet(1, 0, 4, 32'h200);
    push_packet(0, 0, 4, 32'h110);
    run_sources(200);
    for (int k = 0; k < 4; k++) exp_seq.push_back(32'h100 + W'(k));
    for (int k = 0; k < 4; k++) exp_seq.push_back(32'h200 + W'(k));
    for (int k = 0; k < 4; k++) exp_seq.push_back(32'h110 + W'(k));
    check_eq("wormhole_count", 64'(obs.size()), 64'd12);
    for (int k = 0; k < 12 && k < obs.size(); k++)
      check_eq($sformatf("wormhole_seq%0d", k), 64'(obs[k]), 64'(exp_seq[k]));

    // Two VCs interleaving
    push_packet(0, 0, 4, 32'h300);
    push_packet(3, 1, 4, 32'h380);
    run_sources(100);

    // Stall: VC0 flit held with all downstream ready low, then only VC1 ready
    push_packet(0, 0, 3, 32'h400);
    src_cycle();
    push_packet(1, 1, 3, 32'h480);
    out_ready = 2'b00;
    held = bus0.o_out_data;
    repeat (5) begin
      src_cycle();
      check_eq("stall_ready", 64'(acc0), 64'd0);
      check_eq("stall_data", 64'(bus0.o_out_data), 64'(held));
    end
    out_ready = 2'b10;
    repeat (3) begin
      src_cycle();
      check_eq("vc1_only_ready", 64'(acc0), 64'd0);
      check_eq("vc1_only_valid", 64'(bus0.o_out_valid), 64'h1);
    end
    out_ready = 2'b11;
    run_sources(100);

    // Lock rules: non-head on free VC1 and foreign head on locked VC0 both wait
    set_flit(1, 0, 1'b1, 1'b0, 32'h500);
    cycle();
    flit_valid[1*C+0] = 1'b0;
    set_flit(4, 0, 1'b1, 1'b1, 32'h540);
    set_flit(3, 1, 1'b0, 1'b0, 32'h531);
    repeat (10) begin
      cycle();
      check_eq("lock_block_ready", 64'(acc0), 64'd0);
    end
    set_flit(1, 0, 1'b0, 1'b1, 32'h501);
    cycle();
    check_eq("owner_tail_ready", 64'(acc0), 64'd1 << (1*C+0));
    flit_valid[1*C+0] = 1'b0;
    cycle();
    check_eq("next_head_ready", 64'(acc0), 64'd1 << (4*C+0));
    clear_inputs();
    repeat (2) cycle();

    // Asynchronous reset in the middle of a 6-flit packet
    push_packet(2, 1, 6, 32'h600);
    repeat (3) src_cycle();
    drive_sources();
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid_reset");
    model_reset();
    for (int i = 0; i < NC; i++) srcq[i].delete();
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_flit(0, 1, 1'b1, 1'b0, 32'h610);
    cycle();
    check_eq("post_reset_grant", 64'(acc0), 64'd1 << (0*C+1));
    flit_valid[0*C+1] = 1'b0;
    set_flit(0, 1, 1'b0, 1'b1, 32'h611);
    cycle();
    clear_inputs();
    repeat (2) cycle();

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NC; i++) begin
        flit_valid[i] = ($urandom_range(0, 9) < 6);
        flit_head[i]  = ($urandom_range(0, 9) < 3);
        flit_tail[i]  = ($urandom_range(0, 9) < 4);
        flit_data[i*W +: W] = W'($urandom);
      end
      for (int v = 0; v < C; v++) out_ready[v] = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
